// File: rtl/frame_deserializer.sv
// Serial-to-parallel frame receiver: hunts for the sync word, reassembles
// MSB-first payload words and flywheels lock through isolated sync errors.
module frame_deserializer #(
   parameter int                    DATA_WIDTH = 16,
   parameter int                    SYNC_WIDTH = 8,
   parameter logic [SYNC_WIDTH-1:0] SYNC_WORD  = 8'hA5,
   parameter int                    LOCK_COUNT = 2,
   parameter int                    MISS_LIMIT = 3,
   parameter int                    ERR_WIDTH  = 16
) (
   input  logic                  CLOCK_50,
   input  logic                  reset_n,
   input  logic                  bit_in,
   input  logic                  bit_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  locked,
   output logic [ERR_WIDTH-1:0]  sync_err_count,
   output logic [1:0]            state_dbg
);

   typedef enum logic [1:0] {HUNT = 2'd0, PAYLOAD = 2'd1, SYNC_CHECK = 2'd2} state_t;

   localparam int CNT_W  = $clog2(DATA_WIDTH > SYNC_WIDTH ? DATA_WIDTH : SYNC_WIDTH);
   localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
   localparam int MISS_W = $clog2(MISS_LIMIT + 1);

   state_t                 state, state_nxt;
   logic [SYNC_WIDTH-1:0]  win, win_shift;
   logic [DATA_WIDTH-1:0]  pay, pay_shift;
   logic [CNT_W-1:0]       bit_cnt;
   logic [GOOD_W-1:0]      good_cnt, good_nxt;
   logic [MISS_W-1:0]      miss_cnt, miss_nxt;
   logic                   locked_nxt, err_inc, word_done, sync_hit;

   // Comparisons include the bit being accepted on this edge.
   assign win_shift = {win[SYNC_WIDTH-2:0], bit_in};
   assign pay_shift = {pay[DATA_WIDTH-2:0], bit_in};
   assign sync_hit  = (win_shift == SYNC_WORD);
   assign state_dbg = state;

   always_comb begin
      state_nxt  = state;
      good_nxt   = good_cnt;
      miss_nxt   = miss_cnt;
      locked_nxt = locked;
      err_inc    = 1'b0;
      word_done  = 1'b0;
      if (bit_en) begin
         unique case (state)
            HUNT: if (sync_hit) begin
               state_nxt  = PAYLOAD;
               good_nxt   = GOOD_W'(1);
               miss_nxt   = '0;
               locked_nxt = (LOCK_COUNT <= 1);
            end
            PAYLOAD: if (bit_cnt == CNT_W'(DATA_WIDTH-1)) begin
               word_done = 1'b1;
               state_nxt = SYNC_CHECK;
            end
            SYNC_CHECK: if (bit_cnt == CNT_W'(SYNC_WIDTH-1)) begin
               if (sync_hit) begin
                  miss_nxt  = '0;
                  state_nxt = PAYLOAD;
                  if (good_cnt < GOOD_W'(LOCK_COUNT)) good_nxt = good_cnt + 1'b1;
                  if (good_nxt == GOOD_W'(LOCK_COUNT)) locked_nxt = 1'b1;
               end else begin
                  err_inc = 1'b1;
                  if (locked) begin
                     miss_nxt = miss_cnt + 1'b1;
                     if (miss_nxt == MISS_W'(MISS_LIMIT)) begin
                        state_nxt  = HUNT;
                        locked_nxt = 1'b0;
                        good_nxt   = '0;
                        miss_nxt   = '0;
                     end else begin
                        state_nxt = PAYLOAD;   // flywheel: keep alignment
                     end
                  end else begin
                     state_nxt = HUNT;
                     good_nxt  = '0;
                  end
               end
            end
            default: state_nxt = HUNT;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state          <= HUNT;
         win            <= '0;
         pay            <= '0;
         bit_cnt        <= '0;
         good_cnt       <= '0;
         miss_cnt       <= '0;
         locked         <= 1'b0;
         sync_err_count <= '0;
         data_out       <= '0;
         data_valid     <= 1'b0;
      end else begin
         data_valid <= word_done;
         if (bit_en) begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            miss_cnt <= miss_nxt;
            locked   <= locked_nxt;
            if (err_inc && sync_err_count != '1)
               sync_err_count <= sync_err_count + 1'b1;
            // Window restarts from zero on every state change, so HUNT entry is clean.
            if (state_nxt != state)  win <= '0;
            else if (state != PAYLOAD) win <= win_shift;
            if (state_nxt != state || state == HUNT) bit_cnt <= '0;
            else                                      bit_cnt <= bit_cnt + 1'b1;
            if (state == PAYLOAD) pay <= pay_shift;
            if (word_done)        data_out <= pay_shift;
         end
      end
   end

endmodule

// File: tb/tb_frame_deserializer.sv
// Scoreboarded bench: a frame-level reference model walks the accepted bit
// stream and predicts payload words plus lock/error/state after each segment.
module tb_frame_deserializer;
   logic        clk = 1'b0, rst_n = 1'b0, bit_in = 1'b0, bit_en = 1'b0;
   logic [15:0] data_out, sync_err_count;
   logic        data_valid, locked;
   logic [1:0]  state_dbg;

   frame_deserializer dut (
      .CLOCK_50(clk), .reset_n(rst_n), .bit_in(bit_in), .bit_en(bit_en),
      .data_out(data_out), .data_valid(data_valid), .locked(locked),
      .sync_err_count(sync_err_count), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int          errors = 0, checks = 0;
   logic [15:0] exp_q[$];
   bit          stream[$];
   int          sent, pushed;
   logic        m_locked;
   int          m_err, m_state;
   logic [15:0] m_words[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every data_valid pulse must match the oldest predicted word.
   always @(negedge clk) begin
      logic [15:0] e;
      if (rst_n && data_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word: got %0h expected none at %0t", data_out, $time);
         end else begin
            e = exp_q.pop_front();
            check("word", {16'h0, data_out}, {16'h0, e});
         end
      end
   end

   // Reference: hunt for A5 in a zero-cleared window, then slice 16+8 bit frames.
   function automatic void run_model();
      int n, p, good, miss;
      logic [7:0]  w, s;
      logic [15:0] word;
      bit aligned, done;
      n = stream.size(); p = 0; good = 0; miss = 0; done = 0;
      m_locked = 0; m_err = 0; m_state = 0; m_words.delete();
      while (!done) begin
         w = 0; m_state = 0; aligned = 0;
         while (p < n && !aligned) begin
            w = {w[6:0], stream[p]}; p++;
            aligned = (w == 8'hA5);
         end
         if (!aligned) done = 1;
         else begin good = 1; miss = 0; m_state = 1; end
         while (aligned) begin
            if (n - p < 16) begin m_state = 1; aligned = 0; done = 1; end
            else begin
               for (int i = 0; i < 16; i++) word = {word[14:0], stream[p+i]};
               p += 16;
               m_words.push_back(word);
               if (n - p < 8) begin m_state = 2; aligned = 0; done = 1; end
               else begin
                  for (int i = 0; i < 8; i++) s = {s[6:0], stream[p+i]};
                  p += 8;
                  m_state = 1;
                  if (s == 8'hA5) begin
                     miss = 0;
                     if (good < 2) good++;
                     if (good == 2) m_locked = 1;
                  end else begin
                     if (m_err < 65535) m_err++;
                     if (m_locked) begin
                        miss++;
                        if (miss == 3) begin m_locked = 0; good = 0; miss = 0; aligned = 0; end
                     end else begin
                        good = 0; aligned = 0;
                     end
                  end
               end
            end
         end
      end
   endfunction

   task automatic push_bits(input logic [31:0] v, input int w);
      for (int i = w - 1; i >= 0; i--) stream.push_back(v[i]);
   endtask

   // gap: 0 = every cycle, 1 = every 4th cycle, 2 = random 0..3 idle cycles
   task automatic segment(input string name, input int gap);
      run_model();
      for (int i = pushed; i < m_words.size(); i++) exp_q.push_back(m_words[i]);
      pushed = m_words.size();
      for (int i = sent; i < stream.size(); i++) begin
         int g;
         g = (gap == 0) ? 0 : (gap == 1) ? 3 : $urandom_range(0, 3);
         repeat (g) begin @(negedge clk); bit_en = 0; bit_in = 1'($urandom_range(0, 1)); end
         @(negedge clk); bit_en = 1; bit_in = stream[i];
      end
      sent = stream.size();
      @(negedge clk); bit_en = 0;
      check({name, "_locked"}, {31'h0, locked}, {31'h0, m_locked});
      check({name, "_errcnt"}, {16'h0, sync_err_count}, m_err);
      check({name, "_state"},  {30'h0, state_dbg}, m_state);
      @(negedge clk);
      check({name, "_pending"}, exp_q.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clk); rst_n = 0; bit_en = 0;
      repeat (2) @(negedge clk);
      exp_q.delete(); stream.delete(); sent = 0; pushed = 0;
      check("rst_data",   {16'h0, data_out}, 0);
      check("rst_valid",  {31'h0, data_valid}, 0);
      check("rst_locked", {31'h0, locked}, 0);
      check("rst_err",    {16'h0, sync_err_count}, 0);
      check("rst_state",  {30'h0, state_dbg}, 0);
      rst_n = 1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      // Basic stream; lock must rise exactly on the last bit of the second sync.
      do_reset();
      push_bits(8'hA5, 8); push_bits(16'h1234, 16); push_bits(8'hA5 >> 1, 7);
      segment("s1a", 0);
      push_bits(1, 1);
      segment("s1b", 0);
      push_bits(16'hBEEF, 16); push_bits(8'hA5, 8);
      segment("s1c", 0);

      // Same stream, sparse strobes with junk between them.
      do_reset();
      push_bits(8'hA5, 8); push_bits(16'h1234, 16); push_bits(8'hA5, 8);
      push_bits(16'hBEEF, 16); push_bits(8'hA5, 8);
      segment("s2", 1);

      // Near-miss prefix before alignment.
      do_reset();
      push_bits(5'b11101, 5); push_bits(8'hFF, 8); push_bits(8'hFF, 8);
      push_bits(8'hA5, 8); push_bits(16'h00FF, 16);
      segment("s3", 0);

      // Flywheel: one bad sync tolerated, third consecutive drops lock.
      do_reset();
      push_bits(8'hA5, 8); push_bits(16'h1111, 16); push_bits(8'hA5, 8);
      push_bits(16'h2222, 16); push_bits(8'hA4, 8);
      segment("s4a", 0);
      push_bits(16'h5555, 16); push_bits(8'hA5, 8); push_bits(16'h3333, 16);
      push_bits(8'h00, 8); push_bits(16'h4444, 16); push_bits(8'hFF, 8);
      push_bits(16'h6666, 16); push_bits(8'h0F, 8);
      segment("s4b", 0);

      // Unlocked bad sync goes straight back to HUNT.
      do_reset();
      push_bits(8'hA5, 8); push_bits(16'h1234, 16); push_bits(8'h00, 8);
      segment("s5a", 0);
      push_bits(16'h0000, 16);
      segment("s5b", 0);
      push_bits(8'hA5, 8); push_bits(16'h7777, 16);
      segment("s5c", 0);

      // Asynchronous reset mid-payload.
      do_reset();
      push_bits(8'hA5, 8); push_bits(16'h1234, 16); push_bits(8'hA5, 8);
      push_bits(16'h5678, 16); push_bits(8'hA4, 8); push_bits(8'h5A, 8);
      segment("s6a", 0);
      @(posedge clk); #2 rst_n = 0;
      #1;
      check("arst_data",   {16'h0, data_out}, 0);
      check("arst_valid",  {31'h0, data_valid}, 0);
      check("arst_locked", {31'h0, locked}, 0);
      check("arst_err",    {16'h0, sync_err_count}, 0);
      check("arst_state",  {30'h0, state_dbg}, 0);
      @(negedge clk); rst_n = 1;
      exp_q.delete(); stream.delete(); sent = 0; pushed = 0;
      push_bits(8'hA5, 8); push_bits(16'hCAFE, 16);
      segment("s6b", 0);

      // Random frames with occasional corrupted syncs and random strobe gaps.
      do_reset();
      push_bits($urandom_range(0, 255), 8);
      push_bits(8'hA5, 8);
      for (int f = 0; f < 30; f++) begin
         push_bits($urandom_range(0, 65535), 16);
         push_bits(($urandom_range(0, 3) != 0) ? 8'hA5 : 8'($urandom_range(0, 255)), 8);
      end
      segment("s7", 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/frame_deserializer.md
Name: frame_deserializer

Overview:
- Receive-side counterpart of the transmit serializer that turns the 16-bit ADC bus (left byte, right byte) into a bit stream.
- Takes the post-Viterbi serial bit stream, one qualified bit at a time, and finds frame alignment from an 8-bit sync word.
- Reassembles 16-bit payload words and holds lock through isolated sync errors (flywheel).
- Feeds the DAC bus, the BER counter and the seven-segment debug display.

Parameters:
DATA_WIDTH, 16, payload bits per frame, MSB first
SYNC_WIDTH, 8, sync word bits per frame, MSB first
SYNC_WORD, 8'hA5, frame alignment pattern; must be nonzero
LOCK_COUNT, 2, consecutive good syncs (including the hunt match) required to assert locked
MISS_LIMIT, 3, consecutive bad syncs while locked that force a return to HUNT
ERR_WIDTH, 16, width of the saturating sync error counter

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset (driven directly from KEY[0])
bit_in  in  1  serial data bit, valid only when bit_en=1
bit_en  in  1  single-cycle bit qualifier; may be high every cycle
data_out  out  DATA_WIDTH  last completed payload word
data_valid  out  1  one-cycle pulse when data_out updates
locked  out  1  frame lock indicator
sync_err_count  out  ERR_WIDTH  saturating count of bad sync words seen in SYNC_CHECK
state_dbg  out  2  0=HUNT, 1=PAYLOAD, 2=SYNC_CHECK

Behaviour:
Reset and bit acceptance
- Reset is asynchronous. While reset_n=0: all outputs 0, state HUNT, all internal shift registers and counters 0.
- Any partial frame is discarded on reset.
- A bit is accepted only on a rising edge with bit_en=1. Cycles with bit_en=0 change no state; bit_in is don't-care.

HUNT
- An 8-bit window shifts in each accepted bit.
- The window is cleared on every entry to HUNT.
- When the window, including the bit accepted this edge, equals SYNC_WORD: go to PAYLOAD, bit_cnt=0, good_cnt=1, miss_cnt=0.

PAYLOAD
- Shift accepted bits into the payload register, MSB first.
- On the edge accepting bit DATA_WIDTH-1: data_out <= full word (including that bit), data_valid=1 for exactly the following cycle, go to SYNC_CHECK, bit_cnt=0.
- Latency: data_valid is high in the cycle after the edge that accepted the final payload bit.
- Payloads are delivered regardless of locked; locked is the consumer's qualifier.

SYNC_CHECK
- Collect SYNC_WIDTH accepted bits. Evaluate on the edge accepting the last bit.
- Match:
  - miss_cnt=0; good_cnt increments, saturating at LOCK_COUNT.
  - locked=1 when good_cnt reaches LOCK_COUNT.
  - Go to PAYLOAD.
- Mismatch:
  - sync_err_count increments, saturating at all-ones.
  - If locked=1: miss_cnt increments. If the new miss_cnt < MISS_LIMIT, go to PAYLOAD (flywheel: the frame is treated as aligned and its payload is delivered). If the new miss_cnt = MISS_LIMIT, go to HUNT with locked=0 and good_cnt=miss_cnt=0.
  - If locked=0: go to HUNT immediately with good_cnt=0.
- All lock and counter updates are registered on the same edge as the decision.

Timing and boundary rules
- data_valid never pulses in HUNT or SYNC_CHECK except the pulse produced at the PAYLOAD exit edge.
- Back-to-back bit_en (every cycle) is fully supported; there is no backpressure.
- data_out holds its value between pulses.
- sync_err_count is not cleared by loss of lock; only reset clears it.

Test Plan:
- Reset, then stream A5,1234,A5,BEEF,A5 with bit_en every cycle -> data_valid pulses twice: data_out=0x1234, then 0xBEEF. locked rises on the edge accepting the last bit of the second A5. sync_err_count=0.
- Same stream with bit_en every 4th cycle and random bit_in between strobes -> identical data_out sequence and pulse count.
- Prefix with bits 1,1,1,0,1 and 0xFF bytes, then A5,00FF -> alignment found at A5 only; data_out=0x00FF; no data_valid before it.
- Locked, then sync 0xA4 once -> sync_err_count=1, locked stays 1, next payload 0x5555 is delivered. Then three consecutive bad syncs -> locked=0 and state_dbg=0 on the third; the payloads after the first two bad syncs are delivered; sync_err_count=4.
- After a single hunt match (locked=0), second sync 0x00 -> immediate HUNT; following payload bits produce no data_valid until a new A5 plus a full payload.
- Drive reset_n low mid-PAYLOAD between clock edges -> data_out, data_valid, locked, sync_err_count and state_dbg go to 0 immediately. After release, A5,CAFE yields data_out=0xCAFE.
